// File: rtl/sqrt_pipe_ctrl.sv
// Control FSM for an iterative, pipelined square-root datapath.
// Sequences LOAD/RUN/FIX/DONE and counts iterations until the datapath flags overshoot or the limit is hit.
module sqrt_pipe_ctrl #(
    parameter int unsigned ITER_LAT = 4,
    parameter int unsigned MAX_ITER = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       N_i,
    output logic       wr_input_o,
    output logic       en_pipe_o,
    output logic       mux_root_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] iter_o
);

    localparam int unsigned PW = (ITER_LAT > 1) ? $clog2(ITER_LAT) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(ITER_LAT - 1);
    localparam logic [7:0] ITER_LAST = 8'(MAX_ITER - 1);
    localparam logic [7:0] ITER_PRE  = 8'(MAX_ITER - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [7:0]    iter, iter_nxt;
    logic          err, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            phase <= '0;
            iter  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            iter  <= iter_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        iter_nxt  = iter;
        err_nxt   = err;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_LOAD;
                    phase_nxt = '0;
                    iter_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_LOAD: begin
                state_nxt = S_RUN;
                phase_nxt = '0;
            end
            S_RUN: begin
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    if (N_i) begin
                        state_nxt = S_FIX;
                    end else begin
                        if (iter != ITER_LAST) begin
                            iter_nxt = iter + 8'd1;
                        end
                        // The increment that reaches the limit ends the run directly.
                        if (iter == ITER_PRE) begin
                            state_nxt = S_DONE;
                            err_nxt   = 1'b1;
                        end
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_FIX: begin
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    state_nxt = S_DONE;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_comb begin
        wr_input_o = 1'b0;
        en_pipe_o  = 1'b0;
        mux_root_o = 1'b0;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                wr_input_o = 1'b1;
                en_pipe_o  = 1'b1;
            end
            S_RUN: begin
                en_pipe_o = 1'b1;
            end
            S_FIX: begin
                en_pipe_o  = 1'b1;
                mux_root_o = 1'b1;
            end
            S_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign iter_o = iter;
    assign err_o  = err;

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Directed bench for sqrt_pipe_ctrl: default instance plus a MAX_ITER=4 instance for timeout behaviour.
// Expected completions are queued when an operation starts and checked when done_o appears.
module tb_sqrt_pipe_ctrl;

    localparam int LAT = 4;

    typedef struct {
        int done_rel;
        int iter;
        int err;
        int mux_cnt;
        int mux_first;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] start;
    logic [1:0] n;
    logic [1:0] wr, en, mux, rdy, busy, done, err;
    logic [7:0] iter [2];

    int checks;
    int failures;
    exp_t sb[$];

    sqrt_pipe_ctrl #(.ITER_LAT(LAT), .MAX_ITER(256)) dut0 (
        .clk(clk), .rst(rst), .start_i(start[0]), .N_i(n[0]),
        .wr_input_o(wr[0]), .en_pipe_o(en[0]), .mux_root_o(mux[0]), .ready_o(rdy[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .iter_o(iter[0])
    );

    sqrt_pipe_ctrl #(.ITER_LAT(LAT), .MAX_ITER(4)) dut1 (
        .clk(clk), .rst(rst), .start_i(start[1]), .N_i(n[1]),
        .wr_input_o(wr[1]), .en_pipe_o(en[1]), .mux_root_o(mux[1]), .ready_o(rdy[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .iter_o(iter[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_zero(input int s, input string tag);
        chk({tag, "_busy"}, 32'(busy[s]), 0);
        chk({tag, "_done"}, 32'(done[s]), 0);
        chk({tag, "_err"}, 32'(err[s]), 0);
        chk({tag, "_wr"}, 32'(wr[s]), 0);
        chk({tag, "_en"}, 32'(en[s]), 0);
        chk({tag, "_mux"}, 32'(mux[s]), 0);
        chk({tag, "_ready"}, 32'(rdy[s]), 0);
        chk({tag, "_iter"}, 32'(iter[s]), 0);
    endtask

    function automatic exp_t model(input int s, input int fix);
        exp_t e;
        int maxit;
        maxit = (s == 1) ? 4 : 256;
        if (fix >= 0 && fix <= maxit - 2) begin
            e.done_rel  = 2 + LAT * (fix + 2);
            e.iter      = fix;
            e.err       = 0;
            e.mux_cnt   = LAT;
            e.mux_first = e.done_rel - LAT;
        end else begin
            e.done_rel  = 2 + LAT * (maxit - 1);
            e.iter      = maxit - 1;
            e.err       = 1;
            e.mux_cnt   = 0;
            e.mux_first = -1;
        end
        return e;
    endfunction

    // N_i for the cycle 'rel' after the accepted start; only sample points carry meaning.
    function automatic logic nval(input int rel, input int fix, input bit noise);
        if (rel >= 5 && (rel - 5) % LAT == 0) return ((rel - 5) / LAT) == fix;
        if (noise) return (rel == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic op(input int s, input int fix, input bit noise, input bit hold);
        exp_t e;
        int   rel, mux_cnt, mux_first, en_cnt, wr_cnt;
        bit   got, wr_at1;
        tick();
        chk("start_idle_busy", 32'(busy[s]), 0);
        start[s] = 1'b1;
        n[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sb.push_back(model(s, fix));
        rel = 0; got = 0; wr_at1 = 0;
        mux_cnt = 0; mux_first = -1; en_cnt = 0; wr_cnt = 0;
        while (!got && rel < 2000) begin
            tick();
            rel++;
            if (wr[s]) begin
                wr_cnt++;
                if (rel == 1) wr_at1 = 1;
            end
            if (mux[s]) begin
                mux_cnt++;
                if (mux_first < 0) mux_first = rel;
            end
            if (en[s]) en_cnt++;
            if (done[s]) begin
                got = 1;
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", rel, e.done_rel);
                    chk("iter", 32'(iter[s]), e.iter);
                    chk("err", 32'(err[s]), e.err);
                    chk("ready_at_done", 32'(rdy[s]), 1);
                    chk("en_at_done", 32'(en[s]), 0);
                    chk("mux_cycles", mux_cnt, e.mux_cnt);
                    chk("mux_first", mux_first, e.mux_first);
                    chk("en_cycles", en_cnt, e.done_rel - 1);
                    chk("wr_cycles", wr_cnt, 1);
                    chk("wr_at_cycle1", 32'(wr_at1), 1);
                end
                n[s] = 1'b0;
            end else begin
                start[s] = hold;
                n[s] = nval(rel, fix, noise);
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        int dcnt;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = '0;
        n = '0;
        repeat (3) tick();
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst = 1'b0;

        op(0, 0, 0, 0);   // fix at first sample point
        op(0, 3, 0, 0);   // three iterations then fix
        op(0, 5, 1, 0);   // noise off the sample points
        op(1, 1, 0, 0);   // small-limit instance, fix before limit
        op(1, -1, 0, 0);  // timeout
        repeat (3) tick();
        chk("idle_err_hold", 32'(err[1]), 1);
        chk("idle_iter_hold", 32'(iter[1]), 3);
        chk("idle_busy_after_to", 32'(busy[1]), 0);

        op(0, 2, 1, 1);   // start held high through two computations
        op(0, 0, 0, 0);

        // Abort during FIX: start at cycle 0, N_i=1 at cycle 5, rst in cycle 7.
        tick();
        start[0] = 1'b1;
        for (int rel = 1; rel <= 7; rel++) begin
            tick();
            start[0] = 1'b0;
            n[0] = (rel == 5);
        end
        chk("fix_before_rst", 32'(mux[0]), 1);
        rst = 1'b1;
        start[0] = 1'b1;
        tick();
        chk_zero(0, "abort");
        chk("abort_clears_err1", 32'(err[1]), 0);
        chk("abort_clears_iter1", 32'(iter[1]), 0);
        tick();
        chk("rst_over_start", 32'(busy[0]), 0);
        rst = 1'b0;
        start[0] = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done[0]) dcnt++;
        end
        chk("no_done_after_abort", dcnt, 0);
        op(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_pipe_ctrl.md
SQRT_PIPE_CTRL -- requirements
Module: sqrt_pipe_ctrl

Interface
REQ-001 The module SHALL have parameter ITER_LAT, default 4, giving the pipeline cycles per iteration, i.e. the cycles from issuing an iteration to its N flag being valid.
REQ-002 The module SHALL have parameter MAX_ITER, default 256, giving the iteration limit before timeout; legal range is 2..256.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start_i  input  1  request a new square-root computation; sampled only in IDLE.
REQ-006 N_i  input  1  datapath flag: input < current square; qualified only at the sample point.
REQ-007 wr_input_o  output  1  load operand into datapath stage 1.
REQ-008 en_pipe_o  output  1  advance datapath pipeline registers.
REQ-009 mux_root_o  output  1  select root-correction (decrement) path.
REQ-010 ready_o  output  1  capture strobe to datapath final stage.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 err_o  output  1  timeout indicator, valid from done_o until the next start.
REQ-014 iter_o  output  8  count of completed iterations that had N_i=0 at their sample point.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, FIX, DONE; all transitions occur on the rising clk edge.
REQ-016 IDLE: all strobes are 0; start_i=1 transitions to LOAD and clears iter_o, err_o and the phase counter.
REQ-017 LOAD: lasts exactly 1 cycle with wr_input_o=1 and en_pipe_o=1, then transitions to RUN.
REQ-018 RUN:
- en_pipe_o=1 every cycle.
- The phase counter counts 0..ITER_LAT-1 and wraps to 0.
- N_i is sampled only when phase=ITER_LAT-1.
REQ-019 RUN sample-point outcomes:
- N_i=1: transition to FIX with phase cleared; iter_o unchanged.
- N_i=0: iter_o increments and RUN continues.
- N_i=0 and iter_o reaches MAX_ITER-1 at this increment: transition to DONE with err_o set, skipping FIX.
REQ-020 N_i SHALL be ignored in all states and phases other than the RUN sample point, including LOAD, FIX and DONE.
REQ-021 FIX: mux_root_o=1 and en_pipe_o=1 for exactly ITER_LAT cycles, then transition to DONE.
REQ-022 DONE: lasts 1 cycle with ready_o=1, done_o=1 and en_pipe_o=0, then transitions to IDLE.
REQ-023 Outputs wr_input_o, en_pipe_o, mux_root_o, ready_o and done_o SHALL be decoded from registered state only (Moore); no combinational path from start_i or N_i to any output.
REQ-024 start_i asserted outside IDLE SHALL be ignored and not queued; start_i asserted in the DONE cycle is ignored.
REQ-025 start_i held high continuously SHALL start a new computation on the first IDLE cycle after each DONE.
REQ-026 Latency: for start_i sampled in IDLE at cycle 0, with the first N_i=1 seen at iteration n (0-based), done_o SHALL be high at cycle 2+ITER_LAT*(n+2).
REQ-027 Timeout latency: with no N_i=1, done_o SHALL be high at cycle 2+ITER_LAT*(MAX_ITER-1); at that point err_o=1 and iter_o=MAX_ITER-1.
REQ-028 iter_o SHALL saturate at MAX_ITER-1 and never wrap.
REQ-029 iter_o and err_o SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear the phase counter.
REQ-031 rst=1 at a clock edge SHALL clear all outputs: busy_o, done_o, err_o, wr_input_o, en_pipe_o, mux_root_o and ready_o to 0, and iter_o to 0.
REQ-032 rst SHALL take priority over start_i and N_i in the same cycle.
REQ-033 rst asserted mid-operation (any state) SHALL abort the operation with no done_o pulse.

Verification
REQ-034 Default parameters, start_i pulse at cycle 0, N_i=1 at the first sample point (cycle 5) -> wr_input_o=1 at cycle 1 only; mux_root_o=1 cycles 6..9; done_o=ready_o=1 at cycle 10; iter_o=0; err_o=0.
REQ-035 N_i=0 at sample points of iterations 0..2 and N_i=1 at iteration 3 (cycle 17) -> FIX cycles 18..21; done_o at cycle 22; iter_o=3.
REQ-036 N_i toggling randomly at non-sample phases and N_i=1 during LOAD, with N_i=0 at every sample point until iteration 5 -> only sample points affect the flow; done_o at cycle 30; iter_o=5.
REQ-037 MAX_ITER=4, N_i held 0 -> done_o at cycle 14; err_o=1; iter_o=3; mux_root_o never asserted.
REQ-038 start_i held high through two computations -> second LOAD occurs exactly 2 cycles after the first done_o; extra start_i while busy has no effect.
REQ-039 rst asserted during FIX at cycle 7 -> at cycle 8 all outputs are 0 and the FSM is in IDLE; no done_o; a new start_i then proceeds per REQ-026.
